// File: rtl/mul_pkg.sv
// Shared types and widths for the m_cpu execute-stage iterative units.
// The multiplier and the divider both use the operand width defined here.
package mul_pkg;

    localparam int MUL_N = 16;

    typedef enum logic [1:0] {
        MUL    = 2'b00,
        MULH   = 2'b01,
        MULHSU = 2'b10,
        MULHU  = 2'b11
    } mul_op_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } mul_state_e;

endpackage

// File: rtl/mul_seq_if.sv
// Start/busy/done request bundle between the execute stage and the multiplier.
// The master drives operands and start; the slave returns status and results.
interface mul_seq_if
    import mul_pkg::*;
#(
    parameter int N = MUL_N
);
    logic            start;
    mul_op_e         op;
    logic [N-1:0]    rs1_reg;
    logic [N-1:0]    rs2_reg;
    logic            busy;
    logic            done;
    logic [N-1:0]    mul_rd;
    logic [2*N-1:0]  product;

    modport master (
        output start, op, rs1_reg, rs2_reg,
        input  busy, done, mul_rd, product
    );

    modport slave (
        input  start, op, rs1_reg, rs2_reg,
        output busy, done, mul_rd, product
    );
endinterface

// File: rtl/mul_seq.sv
// Iterative shift-add multiplier: sign-magnitude operands, one multiplier bit
// per clock, two's-complement fixup of the 2N-bit product on the final bit.
module mul_seq
    import mul_pkg::*;
#(
    parameter int N = MUL_N
) (
    input  logic     clk,
    input  logic     rst,
    mul_seq_if.slave bus
);

    localparam int CW = $clog2(N);

    mul_state_e      state_reg, state_next;
    mul_op_e         op_reg;
    logic [2*N-1:0]  mcand_reg;
    logic [N-1:0]    mplier_reg;
    logic [2*N-1:0]  acc_reg;
    logic [CW-1:0]   cnt_reg;
    logic            neg_reg;
    logic [2*N-1:0]  product_reg;
    logic [N-1:0]    rd_reg;

    logic            rs1_signed, rs2_signed;
    logic            rs1_neg, rs2_neg;
    logic [N-1:0]    rs1_mag, rs2_mag;
    logic [2*N-1:0]  acc_next;
    logic [2*N-1:0]  prod_fix;
    logic            last_bit;

    // MUL only needs the low half, which is the same for any signedness,
    // so it is run as unsigned like MULHU.
    always_comb begin
        rs1_signed = (bus.op == MULH) || (bus.op == MULHSU);
        rs2_signed = (bus.op == MULH);
        rs1_neg    = rs1_signed && bus.rs1_reg[N-1];
        rs2_neg    = rs2_signed && bus.rs2_reg[N-1];
        // -(-2^(N-1)) wraps back to 2^(N-1), which is the right unsigned magnitude.
        rs1_mag    = rs1_neg ? -bus.rs1_reg : bus.rs1_reg;
        rs2_mag    = rs2_neg ? -bus.rs2_reg : bus.rs2_reg;
    end

    always_comb begin
        acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
        prod_fix = neg_reg ? -acc_next : acc_next;
        last_bit = (cnt_reg == CW'(N - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (last_bit)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_reg      <= MUL;
            mcand_reg   <= '0;
            mplier_reg  <= '0;
            acc_reg     <= '0;
            cnt_reg     <= '0;
            neg_reg     <= 1'b0;
            product_reg <= '0;
            rd_reg      <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        op_reg     <= bus.op;
                        mcand_reg  <= {{N{1'b0}}, rs1_mag};
                        mplier_reg <= rs2_mag;
                        neg_reg    <= rs1_neg ^ rs2_neg;
                        acc_reg    <= '0;
                        cnt_reg    <= '0;
                    end
                end
                RUN: begin
                    acc_reg    <= acc_next;
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    cnt_reg    <= cnt_reg + CW'(1);
                    if (last_bit) begin
                        product_reg <= prod_fix;
                        rd_reg      <= (op_reg == MUL) ? prod_fix[N-1:0] : prod_fix[2*N-1:N];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = (state_reg != IDLE);
    assign bus.done    = (state_reg == DONE);
    assign bus.mul_rd  = rd_reg;
    assign bus.product = product_reg;

endmodule

// File: doc/mul_seq.md
Name: mul_seq

Overview:
- Iterative shift-add multiplier for the m_cpu execute stage; it is the multiply-side counterpart to the divider.
- Accepts two N-bit register operands and an op select covering the MUL/MULH/MULHSU/MULHU variants.
- Retires one multiplier bit per clock and returns the selected N-bit result plus the full 2N-bit product.
- Start/busy/done handshake, so the execute stage can stall on busy.

Parameters:
- N, 16, operand and result width in bits (N ≥ 2).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; accepted only when busy=0.
- op  input  2  00 MUL (low half), 01 MULH (signed×signed, high), 10 MULHSU (rs1 signed × rs2 unsigned, high), 11 MULHU (unsigned×unsigned, high).
- rs1_reg  input  N  multiplicand.
- rs2_reg  input  N  multiplier.
- busy  output  1  high from the accept edge until the DONE cycle ends.
- done  output  1  single-cycle pulse; mul_rd/product are valid while done=1.
- mul_rd  output  N  result selected by op.
- product  output  2N  full product, interpreted per op signedness.

Behaviour:
- Reset values (rst=1 at an edge): state=IDLE, busy=0, done=0, mul_rd=0, product=0, all internal registers cleared.
- rst overrides every other input, including mid-RUN; any in-flight operation is discarded with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge E0 → RUN, busy=1.
  - Latch op.
  - Latch |rs1| and |rs2| as magnitudes. An operand is treated as signed per op (MUL treated as unsigned; low half is sign-independent).
  - Latch neg = sign(rs1)^sign(rs2) over the signed operands.
  - acc=0, cnt=0.
- RUN, one edge per bit:
  - If multiplier LSB=1, acc += multiplicand (2N-bit add, no overflow possible).
  - Multiplicand shifts left 1, multiplier shifts right 1, cnt++.
  - The edge processing bit N-1 (E0+N) → DONE.
  - At that edge: product = neg ? -acc : acc (2N-bit two's complement); mul_rd = product[N-1:0] for op=00, else product[2N-1:N].
- DONE: done=1, busy=1 for exactly one cycle. Next edge → IDLE, done=0.
- Latency: done is high in the cycle after edge E0+N, i.e. N+1 edges after accept, including the DONE→IDLE edge. Throughput: one op per N+2 cycles when start is held high.
- start while busy=1 (RUN or DONE) is ignored; it is not queued.
- mul_rd/product hold their last value after DONE until the next DONE or reset. They are not cleared on a new accept.
- Operand inputs are sampled only at the accept edge; later changes have no effect.
- Most-negative operand (-2^(N-1)): its magnitude 2^(N-1) fits in N unsigned bits; the result must be exact (see tests).
- A zero operand takes the full N cycles; there is no early termination.

Decomposition:
- Package mul_pkg:
  - mul_op_e enum (MUL=2'b00, MULH=2'b01, MULHSU=2'b10, MULHU=2'b11).
  - mul_state_e enum (IDLE, RUN, DONE).
  - Shared width default MUL_N=16, also used by the divider.
- No sub-module. The datapath (acc, shifters, counter, sign fixup) and the FSM form a single ~150-250 line module.

Test Plan:
- Reset mid-op: accept MUL 3×5, assert rst at edge E0+5 → busy=0, done never pulses, mul_rd=0, product=0.
- MUL 0x0003×0x0005 → done exactly 16 edges after accept, one-cycle pulse; mul_rd=0x000F, product=0x0000000F; busy low the cycle after done.
- MULH 0x8000×0x8000 (signed -32768²) → product=0x40000000, mul_rd=0x4000. MUL same operands → mul_rd=0x0000.
- MULHU 0xFFFF×0xFFFF → product=0xFFFE0001, mul_rd=0xFFFE. MULH same operands (-1×-1) → mul_rd=0x0000, product=0x00000001. MULHSU same operands → product=0xFFFF0001, mul_rd=0xFFFF.
- Start while busy: accept MUL 2×7, pulse start with 9×9 during RUN and again in DONE → single done, mul_rd=0x000E, no second operation.
- Back-to-back with start held high: MUL 0x1234×0x0000 then MUL 0x0010×0x0010 with operands changing after each accept → results 0x0000 then 0x0100. Accept edges are N+2 apart; outputs hold between done pulses.
